// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the processing-element sequencer.
// The kernel geometry and the filter-buffer write-mask helper live here.
package pe_seq_pkg;

  localparam int KERNEL_SIZE = 16;
  localparam int LOAD_WIDTH  = 4;
  localparam int LOAD_BEATS  = KERNEL_SIZE / LOAD_WIDTH;
  localparam int SEL_W       = $clog2(KERNEL_SIZE);
  localparam int WIN_W       = 8;
  localparam int BEAT_W      = $clog2(LOAD_BEATS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_ACC,
    S_DRAIN,
    S_FIN
  } state_t;

  // One contiguous group of LOAD_WIDTH enables, positioned by the beat index.
  function automatic logic [KERNEL_SIZE-1:0] load_mask(input logic [BEAT_W-1:0] beat);
    logic [KERNEL_SIZE-1:0] base;
    base = {{(KERNEL_SIZE-LOAD_WIDTH){1'b0}}, {LOAD_WIDTH{1'b1}}};
    return base << (LOAD_WIDTH * int'(beat));
  endfunction

endpackage

// File: rtl/pe_seq_counter.sv
// Generic up-counter with synchronous clear, count enable and terminal-count flag.
// Clear has priority over enable, so callers can wrap to zero on the terminal event.
module pe_seq_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         at_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign at_last = (count == last);

endmodule

// File: rtl/pe_sequencer.sv
// Sequencer for one processing element: loads a 16-tap kernel into the filter buffer,
// then runs num_windows MAC windows (clear, 16 accumulates, drain) reusing that kernel.
module pe_sequencer
  import pe_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIN_W-1:0]       num_windows,
  input  logic                   abort,
  input  logic                   filt_valid,
  output logic                   filt_ready,
  output logic [KERNEL_SIZE-1:0] en1,
  output logic [SEL_W-1:0]       sel,
  output logic                   data_req,
  input  logic                   data_valid,
  output logic                   en2,
  output logic                   rst2,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done
);

  state_t state, state_n;

  logic [WIN_W-1:0]  nw_q;
  logic [BEAT_W-1:0] beat;
  logic              beat_last;
  logic [SEL_W-1:0]  tap;
  logic              tap_last;
  logic [WIN_W-1:0]  win;
  logic              win_last;
  logic              unused_win;

  logic busy_q, done_q, ready_q, req_q, clr_q, drain_q;
  logic start_acc, abort_act, load_fire, acc_fire, drain_go;

  assign start_acc = (state == S_IDLE) && start;
  assign abort_act = abort && (state != S_IDLE);
  // Abort outranks both handshakes in the same cycle.
  assign load_fire = ready_q && filt_valid && !abort_act;
  assign acc_fire  = req_q && data_valid && !abort_act;
  assign drain_go  = drain_q && !abort_act;

  always_ff @(posedge clk) begin
    if (start_acc) begin
      nw_q <= num_windows;
    end
  end

  pe_seq_counter #(.W(BEAT_W)) u_beat_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (abort_act || start_acc || (load_fire && beat_last)),
    .en      (load_fire),
    .last    (BEAT_W'(LOAD_BEATS - 1)),
    .count   (beat),
    .at_last (beat_last)
  );

  pe_seq_counter #(.W(SEL_W)) u_tap_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (abort_act || (acc_fire && tap_last)),
    .en      (acc_fire),
    .last    (SEL_W'(KERNEL_SIZE - 1)),
    .count   (tap),
    .at_last (tap_last)
  );

  // Window terminal is num_windows-1 before the DRAIN increment; a zero count never reaches DRAIN.
  pe_seq_counter #(.W(WIN_W)) u_win_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (abort_act || start_acc || (drain_go && win_last)),
    .en      (drain_go),
    .last    (nw_q - WIN_W'(1)),
    .count   (win),
    .at_last (win_last)
  );

  assign unused_win = ^win;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = (num_windows == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort_act) begin
          state_n = S_IDLE;
        end else if (load_fire && beat_last) begin
          state_n = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_n = abort_act ? S_IDLE : S_ACC;
      end
      S_ACC: begin
        if (abort_act) begin
          state_n = S_IDLE;
        end else if (acc_fire && tap_last) begin
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_act) begin
          state_n = S_IDLE;
        end else begin
          state_n = win_last ? S_FIN : S_CLEAR;
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Moore flags are decoded from the next state so they come straight off flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      req_q   <= 1'b0;
      clr_q   <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state   <= state_n;
      busy_q  <= (state_n != S_IDLE);
      done_q  <= (state_n == S_FIN);
      ready_q <= (state_n == S_LOAD);
      req_q   <= (state_n == S_ACC);
      clr_q   <= (state_n == S_CLEAR);
      drain_q <= (state_n == S_DRAIN);
    end
  end

  assign filt_ready = ready_q;
  assign en1        = load_fire ? load_mask(beat) : '0;
  assign data_req   = req_q;
  assign sel        = req_q ? tap : '0;
  assign en2        = acc_fire;
  assign rst2       = clr_q || abort_act;
  assign out_valid  = drain_go;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer: load masks, window timing, stalls, abort, zero-window jobs
// and asynchronous reset, with expected values written out by hand.
module tb_pe_sequencer;
  import pe_seq_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic [WIN_W-1:0]       num_windows;
  logic                   abort;
  logic                   filt_valid;
  logic                   filt_ready;
  logic [KERNEL_SIZE-1:0] en1;
  logic [SEL_W-1:0]       sel;
  logic                   data_req;
  logic                   data_valid;
  logic                   en2;
  logic                   rst2;
  logic                   out_valid;
  logic                   busy;
  logic                   done;
  logic [26:0]            outs;

  int n_checks = 0;
  int n_fail   = 0;

  pe_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_windows (num_windows),
    .abort       (abort),
    .filt_valid  (filt_valid),
    .filt_ready  (filt_ready),
    .en1         (en1),
    .sel         (sel),
    .data_req    (data_req),
    .data_valid  (data_valid),
    .en2         (en2),
    .rst2        (rst2),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  assign outs = {filt_ready, en1, sel, data_req, en2, rst2, out_valid, busy, done};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [WIN_W-1:0] nw);
    start       = 1'b1;
    num_windows = nw;
    step();
    start       = 1'b0;
  endtask

  task automatic feed_kernel();
    for (int b = 0; b < 4; b++) begin
      filt_valid = 1'b1;
      step();
    end
    filt_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (outs !== 27'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", outs, 27'h0);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_load();
    logic [15:0] exp_en1 [4];
    exp_en1 = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000};
    launch(8'd1);
    for (int b = 0; b < 4; b++) begin
      filt_valid = 1'b1;
      #1;
      n_checks++;
      if (filt_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_ready beat %0d: got %b expected 1", b, filt_ready);
      end
      n_checks++;
      if (en1 !== exp_en1[b]) begin
        n_fail++;
        $display("FAIL load_en1 beat %0d: got %h expected %h", b, en1, exp_en1[b]);
      end
      step();
    end
    filt_valid = 1'b0;
    #1;
    n_checks++;
    if ({rst2, en1, sel} !== {1'b1, 16'h0000, 4'h0}) begin
      n_fail++;
      $display("FAIL load_clear: got rst2=%b en1=%h sel=%h expected rst2=1 en1=0000 sel=0", rst2, en1, sel);
    end
    step();
    data_valid = 1'b1;
    for (int t = 0; t < 16; t++) step();
    data_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL load_drain: got out_valid=%b expected 1", out_valid);
    end
    step();
    #1;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL load_done: got done=%b expected 1", done);
    end
    step();
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_windows();
    int ov[$];
    int done_c;
    int en2_cnt;
    done_c  = 0;
    en2_cnt = 0;
    launch(8'd3);
    feed_kernel();
    data_valid = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      start       = (c == 5);
      num_windows = (c == 5) ? 8'd5 : 8'd3;
      #1;
      if (out_valid === 1'b1) ov.push_back(c);
      if (done === 1'b1) done_c = c;
      if (en2 === 1'b1) en2_cnt++;
      if (c == 11) begin
        n_checks++;
        if (sel !== 4'd9) begin
          n_fail++;
          $display("FAIL win_sel: got %0d expected 9", sel);
        end
      end
      step();
    end
    start      = 1'b0;
    data_valid = 1'b0;
    n_checks++;
    if (ov.size() != 3) begin
      n_fail++;
      $display("FAIL win_count: got %0d out_valid pulses expected 3", ov.size());
    end else begin
      n_checks++;
      if ({ov[0], ov[1], ov[2]} !== {32'd18, 32'd36, 32'd54}) begin
        n_fail++;
        $display("FAIL win_timing: got %0d,%0d,%0d expected 18,36,54", ov[0], ov[1], ov[2]);
      end
    end
    n_checks++;
    if (done_c != 55) begin
      n_fail++;
      $display("FAIL win_done: got cycle %0d expected 55", done_c);
    end
    n_checks++;
    if (en2_cnt != 48) begin
      n_fail++;
      $display("FAIL win_en2: got %0d expected 48", en2_cnt);
    end
  endtask

  task automatic test_stall();
    int ov_c;
    int done_c;
    ov_c   = 0;
    done_c = 0;
    launch(8'd1);
    feed_kernel();
    for (int c = 1; c <= 30; c++) begin
      data_valid = !(c >= 11 && c <= 15);
      #1;
      if (out_valid === 1'b1 && ov_c == 0) ov_c = c;
      if (done === 1'b1) done_c = c;
      if (c >= 11 && c <= 15) begin
        n_checks++;
        if ({sel, en2, data_req} !== {4'd9, 1'b0, 1'b1}) begin
          n_fail++;
          $display("FAIL stall_hold c=%0d: got sel=%0d en2=%b req=%b expected sel=9 en2=0 req=1",
                   c, sel, en2, data_req);
        end
      end
      step();
    end
    data_valid = 1'b0;
    n_checks++;
    if (ov_c != 23) begin
      n_fail++;
      $display("FAIL stall_latency: got cycle %0d expected 23", ov_c);
    end
    n_checks++;
    if (done_c != 24) begin
      n_fail++;
      $display("FAIL stall_done: got cycle %0d expected 24", done_c);
    end
  endtask

  task automatic test_abort_load();
    bit done_seen;
    done_seen = 1'b0;
    launch(8'd2);
    filt_valid = 1'b0;
    #1;
    n_checks++;
    if ({filt_ready, en1} !== {1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL gap_en1: got ready=%b en1=%h expected ready=1 en1=0000", filt_ready, en1);
    end
    step();
    filt_valid = 1'b1;
    step();
    step();
    abort = 1'b1;
    #1;
    if (done === 1'b1) done_seen = 1'b1;
    n_checks++;
    if (en1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL abort_en1: got %h expected 0000", en1);
    end
    n_checks++;
    if (rst2 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_rst2: got %b expected 1", rst2);
    end
    step();
    abort      = 1'b0;
    filt_valid = 1'b0;
    #1;
    n_checks++;
    if ({busy, filt_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b ready=%b expected 0 0", busy, filt_ready);
    end
    for (int c = 0; c < 8; c++) begin
      if (done === 1'b1) done_seen = 1'b1;
      step();
    end
    n_checks++;
    if (done_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got done seen=%b expected 0", done_seen);
    end
  endtask

  task automatic test_zero_windows();
    bit ctl_seen;
    ctl_seen    = 1'b0;
    num_windows = 8'd0;
    start       = 1'b1;
    #1;
    if (en1 !== '0 || en2 !== 1'b0 || rst2 !== 1'b0) ctl_seen = 1'b1;
    step();
    start = 1'b0;
    #1;
    if (en1 !== '0 || en2 !== 1'b0 || rst2 !== 1'b0) ctl_seen = 1'b1;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: got %b expected 1", done);
    end
    step();
    #1;
    if (en1 !== '0 || en2 !== 1'b0 || rst2 !== 1'b0) ctl_seen = 1'b1;
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL zero_after: got done=%b busy=%b expected 0 0", done, busy);
    end
    n_checks++;
    if (ctl_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_ctl: got en1/en2/rst2 activity=%b expected 0", ctl_seen);
    end
  endtask

  task automatic test_reset_mid_acc();
    logic [15:0] exp_en1 [4];
    exp_en1 = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000};
    launch(8'd1);
    feed_kernel();
    data_valid = 1'b1;
    step();
    for (int t = 0; t < 7; t++) step();
    #1;
    n_checks++;
    if (sel !== 4'd7) begin
      n_fail++;
      $display("FAIL rst_pre_sel: got %0d expected 7", sel);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs !== 27'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %h expected %h", outs, 27'h0);
    end
    data_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    launch(8'd1);
    for (int b = 0; b < 4; b++) begin
      filt_valid = 1'b1;
      #1;
      n_checks++;
      if (en1 !== exp_en1[b]) begin
        n_fail++;
        $display("FAIL rst_reload beat %0d: got %h expected %h", b, en1, exp_en1[b]);
      end
      step();
    end
    filt_valid = 1'b0;
    #1;
    n_checks++;
    if (rst2 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_reload_clear: got %b expected 1", rst2);
    end
    step();
    data_valid = 1'b1;
    for (int t = 0; t < 16; t++) step();
    data_valid = 1'b0;
    step();
    step();
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_reload_idle: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    filt_valid  = 1'b0;
    data_valid  = 1'b0;
    num_windows = '0;
    step();
    test_reset();
    step();
    rst_n = 1'b1;
    step();
    test_load();
    step();
    test_windows();
    step();
    test_stall();
    step();
    test_abort_load();
    step();
    test_zero_windows();
    step();
    test_reset_mid_acc();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
